// File: rtl/load_store_unit.sv
// load_store_unit: turns one core load/store request (byte or halfword) into
// a sequence of single-byte accesses on a registered-read byte memory.
//   clk, reset       : rising-edge clock, asynchronous active-high reset
//   req_*            : request handshake (valid/ready), kind, address, store data
//   resp_valid/rdata : one-cycle completion pulse and load result (0 for stores)
//   mem_*            : byte memory port; mem_rdata is valid one cycle after mem_addr
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_half,
  input  logic        req_signed,
  input  logic [7:0]  req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_LO   = 3'd1;
  localparam logic [2:0] RD_HI   = 3'd2;
  localparam logic [2:0] RD_WAIT = 3'd3;
  localparam logic [2:0] WR_LO   = 3'd4;
  localparam logic [2:0] WR_HI   = 3'd5;
  localparam logic [2:0] RESP    = 3'd6;

  logic [2:0]    state_q, state_d;
  logic          half_q, signed_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [7:0]    lo_q, lo_d;
  logic [DW-1:0] rdata_d;
  logic          accept_c;
  logic [AW-1:0] addr_sel_c, addr_inc_c;
  logic [DW-1:0] wdata_sel_c;
  logic          mem_we_d, req_ready_d, resp_valid_d;
  logic [AW-1:0] mem_addr_d;
  logic [7:0]    mem_wdata_d;

  assign accept_c   = (state_q == IDLE) & req_valid & req_ready;
  // First access of a request uses the live request fields, later ones the latched copy.
  assign addr_sel_c  = accept_c ? req_addr  : addr_q;
  assign wdata_sel_c = accept_c ? req_wdata : wdata_q;
  // Halfword high byte address wraps naturally at 8'hFF.
  assign addr_inc_c  = AW'(addr_q + AW'(1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state, read-data assembly and next-cycle output decode
  always_comb begin
    state_d      = state_q;
    lo_d         = lo_q;
    rdata_d      = resp_rdata;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    case (state_q)
      IDLE:    if (accept_c) state_d = req_write ? WR_LO : RD_LO;
      WR_LO: begin
        state_d = half_q ? WR_HI : RESP;
        if (!half_q) rdata_d = '0;
      end
      WR_HI: begin
        state_d = RESP;
        rdata_d = '0;
      end
      RD_LO:   state_d = half_q ? RD_HI : RD_WAIT;
      RD_HI: begin
        state_d = RD_WAIT;
        lo_d    = mem_rdata;
      end
      RD_WAIT: begin
        state_d = RESP;
        rdata_d = half_q ? {mem_rdata, lo_q}
                         : {{8{mem_rdata[7] & signed_q}}, mem_rdata};
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so decode them from the state being entered.
    case (state_d)
      WR_LO: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_sel_c;
        mem_wdata_d = wdata_sel_c[7:0];
      end
      WR_HI: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_inc_c;
        mem_wdata_d = wdata_q[15:8];
      end
      RD_LO:   mem_addr_d = addr_sel_c;
      RD_HI:   mem_addr_d = addr_inc_c;
      default: ;
    endcase
    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  // Request latch and low-byte holding register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_q   <= 1'b0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lo_q     <= '0;
    end else begin
      if (accept_c) begin
        half_q   <= req_half;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      lo_q <= lo_d;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= rdata_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: byte memory model on the mem port, reference
// memory image plus per-request expected result/latency computed from the
// access rules, directed corner cases, random traffic and mid-flight resets.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_half, req_signed;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        mem_we;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  int checks = 0;
  int passed = 0;
  int accept_count = 0;
  int resp_count = 0;
  int we_cycles = 0;
  int exp_accepts = 0;
  int exp_resps = 0;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_half(req_half), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte memory with one-cycle registered read
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Handshake / pulse monitors
  always @(posedge clk) begin
    if (!reset && req_valid && req_ready) accept_count <= accept_count + 1;
    if (!reset && resp_valid) resp_count <= resp_count + 1;
    if (!reset && mem_we) we_cycles <= we_cycles + 1;
  end

  // One request end to end; keep=1 leaves req_valid high afterwards.
  task automatic do_txn(input logic w, input logic h, input logic s,
                        input logic [7:0] a, input logic [15:0] d,
                        input logic keep, input string name);
    int lat;
    logic [15:0] exp;
    logic [7:0] a1, b;
    int n;
    int cyc;
    logic got;
    logic ready_ok;
    a1 = a + 8'd1;
    if (w) begin
      lat = h ? 3 : 2;
      exp = 16'h0000;
    end else begin
      lat = h ? 4 : 3;
      b = ref_mem[a];
      if (h) exp = {ref_mem[a1], ref_mem[a]};
      else   exp = {(s && b[7]) ? 8'hFF : 8'h00, b};
    end
    @(negedge clk);
    req_write = w; req_half = h; req_signed = s; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) $display("FAIL %s accept: req_ready=%0b required 1", name, req_ready);
    else passed++;
    @(posedge clk);
    exp_accepts++;
    if (!keep) begin
      #1 req_valid = 1'b0;
    end
    if (w) begin
      ref_mem[a] = d[7:0];
      if (h) ref_mem[a1] = d[15:8];
    end
    cyc = 0; got = 1'b0; ready_ok = 1'b1;
    while (!got && cyc < 10) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (req_ready) ready_ok = 1'b0;
      if (resp_valid) got = 1'b1;
    end
    exp_resps++;
    // resp_valid is seen by the core on the edge after it rises
    checks++;
    if (!got || cyc + 1 != lat)
      $display("FAIL %s latency: got=%0b cycles=%0d required %0d", name, got, cyc + 1, lat);
    else passed++;
    checks++;
    if (resp_rdata !== exp)
      $display("FAIL %s rdata: %h required %h", name, resp_rdata, exp);
    else passed++;
    checks++;
    if (!ready_ok) $display("FAIL %s busy_ready: req_ready=1 while busy, required 0", name);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_half = 1'b0;
    req_signed = 1'b0; req_addr = 8'h00; req_wdata = 16'h0000;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 16'h0000 ||
        mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00)
      $display("FAIL reset_values: ready=%b rv=%b rd=%h we=%b ad=%h wd=%h required 1 0 0000 0 00 00",
               req_ready, resp_valid, resp_rdata, mem_we, mem_addr, mem_wdata);
    else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_we !== 1'b0)
      $display("FAIL idle_hold: ready=%b rv=%b we=%b required 1 0 0", req_ready, resp_valid, mem_we);
    else passed++;
  endtask

  task automatic test_directed();
    int w0;
    w0 = we_cycles;
    do_txn(1'b1, 1'b0, 1'b0, 8'h10, 16'h00AB, 1'b0, "byte_store");
    checks++;
    if (we_cycles - w0 != 1 || mem[8'h10] !== 8'hAB)
      $display("FAIL byte_store_mem: we_cycles=%0d mem=%h required 1 AB", we_cycles - w0, mem[8'h10]);
    else passed++;
    w0 = we_cycles;
    do_txn(1'b1, 1'b1, 1'b0, 8'hFF, 16'h1234, 1'b0, "half_store_wrap");
    checks++;
    if (we_cycles - w0 != 2 || mem[8'hFF] !== 8'h34 || mem[8'h00] !== 8'h12)
      $display("FAIL half_store_wrap_mem: we_cycles=%0d FF=%h 00=%h required 2 34 12",
               we_cycles - w0, mem[8'hFF], mem[8'h00]);
    else passed++;
    do_txn(1'b0, 1'b1, 1'b0, 8'hFF, 16'h0000, 1'b0, "half_load_wrap");
    checks++;
    if (resp_rdata !== 16'h1234) $display("FAIL half_load_value: %h required 1234", resp_rdata);
    else passed++;
    do_txn(1'b1, 1'b0, 1'b0, 8'h40, 16'h5580, 1'b0, "store_80");
    do_txn(1'b0, 1'b0, 1'b1, 8'h40, 16'h0000, 1'b0, "load_signed");
    checks++;
    if (resp_rdata !== 16'hFF80) $display("FAIL load_signed_value: %h required FF80", resp_rdata);
    else passed++;
    do_txn(1'b0, 1'b0, 1'b0, 8'h40, 16'h0000, 1'b0, "load_unsigned");
    checks++;
    if (resp_rdata !== 16'h0080) $display("FAIL load_unsigned_value: %h required 0080", resp_rdata);
    else passed++;
    // Response data must stay put while idle
    repeat (3) @(negedge clk);
    checks++;
    if (resp_rdata !== 16'h0080 || resp_valid !== 1'b0)
      $display("FAIL rdata_hold: rd=%h rv=%b required 0080 0", resp_rdata, resp_valid);
    else passed++;
  endtask

  task automatic rand_txn(input logic keep, input string name);
    logic [7:0] a;
    a = 8'($urandom_range(0, 15)) ^ (($urandom_range(0, 1) == 1) ? 8'hF0 : 8'h00);
    do_txn(1'($urandom), 1'($urandom), 1'($urandom), a, 16'($urandom), keep, name);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) rand_txn(1'b0, "random");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 25; i++) rand_txn(1'b1, "back_to_back");
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (accept_count != exp_accepts || resp_count != exp_resps)
      $display("FAIL transfer_count: accepts=%0d resps=%0d required %0d %0d",
               accept_count, resp_count, exp_accepts, exp_resps);
    else passed++;
  endtask

  // Reset during the second byte of a halfword access (store then load).
  task automatic test_reset_midflight(input logic w, input string name);
    int r0;
    @(negedge clk);
    req_write = w; req_half = 1'b1; req_signed = 1'b0; req_addr = 8'h55;
    req_wdata = 16'hBEEF; req_valid = 1'b1;
    @(posedge clk);
    exp_accepts++;
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mem_we !== w || mem_addr !== 8'h56)
      $display("FAIL %s second_byte: we=%b addr=%h required %b 56", name, mem_we, mem_addr, w);
    else passed++;
    if (w) ref_mem[8'h55] = 8'hEF;
    r0 = resp_count;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== 8'h00 || mem_wdata !== 8'h00)
      $display("FAIL %s async_reset: ready=%b rv=%b we=%b ad=%h wd=%h required 1 0 0 00 00",
               name, req_ready, resp_valid, mem_we, mem_addr, mem_wdata);
    else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (resp_count != r0 || req_ready !== 1'b1)
      $display("FAIL %s no_response: resps=%0d ready=%b required %0d 1", name, resp_count, req_ready, r0);
    else passed++;
  endtask

  task automatic test_memory_image();
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) $display("FAIL memory_image: %0d bytes differ, required 0", bad);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midflight(1'b1, "reset_wr_hi");
    test_reset_midflight(1'b0, "reset_rd_hi");
    test_memory_image();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge system clock.
REQ-002 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high; clock clk.
REQ-003 SHALL have port req_valid, input, 1 bit: core presents an access request.
REQ-004 SHALL have port req_ready, output, 1 bit: unit accepts a request this cycle.
REQ-005 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-006 SHALL have port req_half, input, 1 bit: 1 = 16-bit halfword, 0 = 8-bit byte.
REQ-007 SHALL have port req_signed, input, 1 bit: byte load sign-extends when 1, zero-extends when 0.
REQ-008 SHALL have port req_addr, input, 8 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 16 bits: store data; byte store uses bits [7:0].
REQ-010 SHALL have port resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 16 bits: load result, valid while resp_valid=1.
REQ-012 SHALL have port mem_we, output, 1 bit: memory write enable.
REQ-013 SHALL have port mem_addr, output, 8 bits: memory address.
REQ-014 SHALL have port mem_wdata, output, 8 bits: memory write data.
REQ-015 SHALL have port mem_rdata, input, 8 bits: memory read data, registered, valid the cycle after the address is presented.

Function
REQ-016 SHALL implement FSM states IDLE, RD_LO, RD_HI, RD_WAIT, WR_LO, WR_HI, RESP.
REQ-017 SHALL drive req_ready=1 only in IDLE; accept on req_valid & req_ready; latch write, half, signed, addr and wdata at the accept edge.
REQ-018 SHALL on accept transition IDLE->WR_LO for stores and IDLE->RD_LO for loads; with req_valid=0, IDLE SHALL hold.
REQ-019 SHALL in WR_LO drive mem_we=1, mem_addr=A, mem_wdata=D[7:0]; next state WR_HI if half, else RESP.
REQ-020 SHALL in WR_HI drive mem_we=1, mem_addr=(A+1) mod 256, mem_wdata=D[15:8]; next RESP.
REQ-021 SHALL in RD_LO drive mem_we=0, mem_addr=A; next RD_HI if half, else RD_WAIT.
REQ-022 SHALL in RD_HI drive mem_addr=(A+1) mod 256 and capture mem_rdata into the low byte at exit; next RD_WAIT.
REQ-023 SHALL in RD_WAIT capture mem_rdata into the high byte (half) or the low byte (byte) at exit; next RESP.
REQ-024 SHALL in RESP assert resp_valid for exactly one cycle; next IDLE; no back-pressure on the response.
REQ-025 SHALL present resp_rdata for byte loads as {8{b[7]&signed},b}, for halfword loads as {hi,lo} (little-endian), and for stores as 16'h0000.
REQ-026 SHALL hold resp_rdata stable from RESP until the next RESP.
REQ-027 SHALL drive mem_we=0, mem_addr=8'h00 and mem_wdata=8'h00 in IDLE, RESP, RD_* (wdata only) and all non-write states.
REQ-028 SHALL meet these accept-edge-to-resp_valid latencies: byte store 2 cycles, halfword store 3, byte load 3, halfword load 4.
REQ-029 SHALL wrap the halfword address at 8'hFF so the high byte comes from 8'h00; no error is raised.

Reset
REQ-030 SHALL on reset assert force IDLE immediately and set resp_valid=0, resp_rdata=16'h0000, mem_we=0, mem_addr=8'h00, mem_wdata=8'h00, req_ready=1.
REQ-031 SHALL abort any in-flight access on reset with no response; a halfword store interrupted after WR_LO leaves only the low byte written.

Verification
REQ-032 Byte store A=8'h10, D=16'h00AB -> one cycle mem_we=1, addr 10, wdata AB; resp_valid 2 cycles after accept, rdata 0000.
REQ-033 Halfword store A=8'hFF, D=16'h1234 -> writes 34@FF then 12@00; a following halfword load A=FF returns 16'h1234 at 4 cycles.
REQ-034 Byte load of 8'h80 with signed=1 -> FF80; with signed=0 -> 0080.
REQ-035 req_valid held high continuously -> req_ready low from accept to the cycle after RESP; second request accepted only in IDLE; no dropped or duplicated transfers.
REQ-036 Reset asserted during WR_HI or RD_HI -> outputs reach reset values asynchronously, no resp_valid, req_ready=1 after release.
